// File: rtl/median_pkg.sv
//------------------------------------------------------------------------------
// median_pkg : shared states, window geometry and slot offsets for the
//              3x3 median window sequencer.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package median_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    DRAIN    = 3'd2,
    HANDOFF  = 3'd3,
    WAIT_RES = 3'd4,
    WRITE    = 3'd5,
    ADVANCE  = 3'd6,
    DONE     = 3'd7
  } state_t;

  localparam int         WIN_SLOTS   = 9;
  localparam logic [3:0] SLOT_CENTRE = 4'd4;
  localparam logic [3:0] SLOT_LAST   = 4'd8;

  // Slot k sits at (dy, dx) = (k/3 - 1, k%3 - 1) around the centre pixel.
  function automatic logic signed [1:0] slot_dy(input logic [3:0] k);
    case (k)
      4'd0, 4'd1, 4'd2: return -2'sd1;
      4'd3, 4'd4, 4'd5: return 2'sd0;
      default:          return 2'sd1;
    endcase
  endfunction

  function automatic logic signed [1:0] slot_dx(input logic [3:0] k);
    case (k)
      4'd0, 4'd3, 4'd6: return -2'sd1;
      4'd1, 4'd4, 4'd7: return 2'sd0;
      default:          return 2'sd1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/median_win_addr_gen.sv
//------------------------------------------------------------------------------
// median_win_addr_gen : clamps a window slot's neighbour coordinates to the
//                       image and forms its linear memory address.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module median_win_addr_gen
  import median_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12,
  parameter int ROW_W  = 6,
  parameter int COL_W  = 6
) (
  input  logic [ROW_W-1:0]  row,
  input  logic [COL_W-1:0]  col,
  input  logic [3:0]        slot,
  output logic [ADDR_W-1:0] addr
);

  // Two extra bits: sign, plus headroom for row+1 when the height is a power of two.
  localparam int YW = ROW_W + 2;
  localparam int XW = COL_W + 2;
  localparam logic signed [YW-1:0] Y_MAX = YW'(IMG_H - 1);
  localparam logic signed [XW-1:0] X_MAX = XW'(IMG_W - 1);

  logic signed [1:0]    dy;
  logic signed [1:0]    dx;
  logic signed [YW-1:0] yy;
  logic signed [XW-1:0] xx;
  logic [ROW_W-1:0]     yc;
  logic [COL_W-1:0]     xc;

  always_comb begin
    dy = slot_dy(slot);
    dx = slot_dx(slot);
    yy = $signed({2'b00, row}) + $signed({{ROW_W{dy[1]}}, dy});
    xx = $signed({2'b00, col}) + $signed({{COL_W{dx[1]}}, dx});

    if (yy < 0)          yc = '0;
    else if (yy > Y_MAX) yc = ROW_W'(IMG_H - 1);
    else                 yc = yy[ROW_W-1:0];

    if (xx < 0)          xc = '0;
    else if (xx > X_MAX) xc = COL_W'(IMG_W - 1);
    else                 xc = xx[COL_W-1:0];

    addr = ADDR_W'(int'(yc) * IMG_W + int'(xc));
  end

endmodule

`default_nettype wire

// File: rtl/median_window_sched.sv
//------------------------------------------------------------------------------
// median_window_sched : walks an image pixel by pixel, gathers each clamped
//                       3x3 window, hands it to the median core, writes result.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module median_window_sched
  import median_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_en,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic [PIX_W-1:0]       rd_data,
  output logic [9*PIX_W-1:0]     win_data,
  output logic                   win_valid,
  input  logic                   win_ready,
  input  logic                   res_valid,
  input  logic [PIX_W-1:0]       res_data,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [PIX_W-1:0]       wr_data
);

  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [3:0]       DRAIN_END = 4'(RD_LAT - 1);

  state_t             state;
  state_t             next_state;
  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   col;
  logic [3:0]         slot;
  logic [PIX_W-1:0]   win [WIN_SLOTS];
  logic [PIX_W-1:0]   result;
  logic [RD_LAT-1:0]  vld_sr;
  logic [3:0]         tag_sr [RD_LAT];
  logic [ADDR_W-1:0]  rd_addr_calc;
  logic [ADDR_W-1:0]  wr_addr_calc;
  logic               last_pixel;

  assign last_pixel = (row == ROW_LAST) && (col == COL_LAST);

  median_win_addr_gen #(
    .IMG_W (IMG_W), .IMG_H (IMG_H), .ADDR_W (ADDR_W), .ROW_W (ROW_W), .COL_W (COL_W)
  ) u_rd_addr (
    .row (row), .col (col), .slot (slot), .addr (rd_addr_calc)
  );

  // Centre slot has zero offset, so this yields row*IMG_W+col.
  median_win_addr_gen #(
    .IMG_W (IMG_W), .IMG_H (IMG_H), .ADDR_W (ADDR_W), .ROW_W (ROW_W), .COL_W (COL_W)
  ) u_wr_addr (
    .row (row), .col (col), .slot (SLOT_CENTRE), .addr (wr_addr_calc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      row    <= '0;
      col    <= '0;
      slot   <= '0;
      result <= '0;
      vld_sr <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_sr[i] <= '0;
      for (int k = 0; k < WIN_SLOTS; k++) win[k] <= '0;
    end else begin
      state <= next_state;

      // Each read's slot index travels alongside its valid bit until the data lands.
      vld_sr[0] <= rd_en;
      tag_sr[0] <= slot;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        tag_sr[i] <= tag_sr[i-1];
      end
      if (vld_sr[RD_LAT-1]) win[tag_sr[RD_LAT-1]] <= rd_data;

      case (state)
        IDLE: begin
          slot <= '0;
          if (start) begin
            row <= '0;
            col <= '0;
          end
        end
        FETCH:    slot <= (slot == SLOT_LAST) ? 4'd0 : slot + 4'd1;
        DRAIN:    slot <= (slot == DRAIN_END) ? 4'd0 : slot + 4'd1;
        WAIT_RES: if (res_valid) result <= res_data;
        ADVANCE: begin
          if (!last_pixel) begin
            if (col == COL_LAST) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DONE: begin
          row <= '0;
          col <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    rd_en      = 1'b0;
    win_valid  = 1'b0;
    wr_en      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:     if (start) next_state = FETCH;
      FETCH: begin
        rd_en = 1'b1;
        if (slot == SLOT_LAST) next_state = DRAIN;
      end
      DRAIN:    if (slot == DRAIN_END) next_state = HANDOFF;
      HANDOFF: begin
        win_valid = 1'b1;
        if (win_ready) next_state = WAIT_RES;
      end
      WAIT_RES: if (res_valid) next_state = WRITE;
      WRITE: begin
        wr_en      = 1'b1;
        next_state = ADVANCE;
      end
      ADVANCE:  next_state = last_pixel ? DONE : FETCH;
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default:  next_state = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign rd_addr = rd_en ? rd_addr_calc : '0;
  assign wr_addr = wr_en ? wr_addr_calc : '0;
  assign wr_data = wr_en ? result : '0;

  for (genvar k = 0; k < WIN_SLOTS; k++) begin : g_pack
    assign win_data[k*PIX_W +: PIX_W] = win[k];
  end

endmodule

`default_nettype wire

// File: tb/tb_median_window_sched.sv
//------------------------------------------------------------------------------
// tb_median_window_sched : directed bench on a 4x3 image, RD_LAT=1 and RD_LAT=3.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_median_window_sched;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int PW = 8;
  localparam int AW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;
  logic start = 1'b0;

  logic          busy_a, done_a, rd_en_a, win_valid_a, wr_en_a;
  logic [AW-1:0] rd_addr_a, wr_addr_a;
  logic [PW-1:0] rd_data_a, wr_data_a;
  logic [PW-1:0] res_data_a = '0;
  logic [9*PW-1:0] win_data_a;
  logic          win_ready_a = 1'b0;
  logic          res_valid_a = 1'b0;

  logic          busy_b, done_b, rd_en_b, win_valid_b, wr_en_b;
  logic [AW-1:0] rd_addr_b, wr_addr_b;
  logic [PW-1:0] rd_data_b, wr_data_b;
  logic [PW-1:0] res_data_b = '0;
  logic [9*PW-1:0] win_data_b;
  logic          win_ready_b = 1'b0;
  logic          res_valid_b = 1'b0;

  median_window_sched #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .ADDR_W(AW), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .busy(busy_a), .done(done_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .win_data(win_data_a), .win_valid(win_valid_a), .win_ready(win_ready_a),
    .res_valid(res_valid_a), .res_data(res_data_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a)
  );

  median_window_sched #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .ADDR_W(AW), .RD_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .start(start), .busy(busy_b), .done(done_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .win_data(win_data_b), .win_valid(win_valid_b), .win_ready(win_ready_b),
    .res_valid(res_valid_b), .res_data(res_data_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b)
  );

  // Source RAM models: the k-th read of every pixel returns 10+k.
  int ra_cnt = 0;
  int rb_cnt = 0;
  logic [PW-1:0] pb [3];
  always @(posedge clk) begin
    if (!rst) ra_cnt <= 0;
    else if (rd_en_a) begin
      rd_data_a <= PW'(10 + ra_cnt % 9);
      ra_cnt    <= ra_cnt + 1;
    end
    if (!rst) rb_cnt <= 0;
    else if (rd_en_b) rb_cnt <= rb_cnt + 1;
    pb[0] <= PW'(10 + rb_cnt % 9);
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign rd_data_b = pb[2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rdq[$];
  int wr_addr_q[$];
  int wr_data_q[$];
  int done_cnt = 0;
  int a_first = -1;
  int b_first = -1;
  int b_vcyc  = -1;

  always @(negedge clk) begin
    if (rd_en_a) begin
      if (rdq.size() == 0) a_first = cyc;
      rdq.push_back(int'(rd_addr_a));
    end
    if (wr_en_a) begin
      wr_addr_q.push_back(int'(wr_addr_a));
      wr_data_q.push_back(int'(wr_data_a));
    end
    if (done_a) done_cnt++;
    if (rd_en_b && b_first < 0) b_first = cyc;
    if (win_valid_b && b_vcyc < 0) b_vcyc = cyc;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_res(input int p);
    return (37 * p + 5) % 256;
  endfunction

  int exp_rd [3][9] = '{
    '{0, 0, 1, 0, 0, 1, 4, 4, 5},
    '{0, 1, 2, 4, 5, 6, 8, 9, 10},
    '{6, 7, 7, 10, 11, 11, 10, 11, 11}
  };

  task automatic wait_valid(output bit ok, output int vcyc);
    ok = 1'b0;
    vcyc = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (win_valid_a) begin
        ok = 1'b1;
        vcyc = cyc;
        break;
      end
    end
    if (!ok) chk("win_valid_timeout", 0, 1);
  endtask

  task automatic do_pixel(input int p, input int hold);
    bit ok;
    int vcyc;
    int tab;
    logic [9*PW-1:0] snap;
    win_ready_a = (hold == 0);
    wait_valid(ok, vcyc);
    if (!ok) return;
    chk($sformatf("reads_p%0d", p), rdq.size(), 9);
    tab = (p == 0) ? 0 : (p == 5) ? 1 : (p == 11) ? 2 : -1;
    if (tab >= 0)
      for (int k = 0; k < 9 && k < rdq.size(); k++)
        chk($sformatf("rd_addr_p%0d_s%0d", p, k), rdq[k], exp_rd[tab][k]);
    if (p <= 1)
      for (int k = 0; k < 9; k++)
        chk($sformatf("win_slot_p%0d_s%0d", p, k), win_data_a[k*PW +: PW], 10 + k);
    if (p == 0) chk("fill_latency_lat1", vcyc - a_first, 10);
    rdq.delete();
    if (hold > 0) begin
      snap = win_data_a;
      for (int i = 0; i < hold; i++) begin
        res_valid_a = (i == 2);
        res_data_a  = (i == 2) ? 8'hEE : 8'h00;
        @(negedge clk);
        res_valid_a = 1'b0;
        chk("hold_valid", win_valid_a, 1);
        chk("hold_data_stable", win_data_a == snap, 1);
      end
      win_ready_a = 1'b1;
    end
    @(negedge clk);
    win_ready_a = 1'b0;
    chk($sformatf("valid_drop_p%0d", p), win_valid_a, 0);
    @(negedge clk);
    res_valid_a = 1'b1;
    res_data_a  = PW'(exp_res(p));
    @(negedge clk);
    res_valid_a = 1'b0;
    chk($sformatf("wr_en_p%0d", p), wr_en_a, 1);
  endtask

  initial begin
    int done_before;
    bit seen;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_rd_en", rd_en_a, 0);
    chk("rst_rd_addr", rd_addr_a, 0);
    chk("rst_win_valid", win_valid_a, 0);
    chk("rst_win_data_zero", win_data_a == '0, 1);
    chk("rst_wr_en", wr_en_a, 0);
    chk("rst_wr_addr", wr_addr_a, 0);
    chk("rst_wr_data", wr_data_a, 0);
    chk("rst_busy_b", busy_b, 0);

    rst = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy_a, 1);

    for (int p = 0; p < W * H; p++) do_pixel(p, (p == 1) ? 5 : 0);

    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_a) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", seen, 1);
    @(negedge clk);
    chk("busy_after_done", busy_a, 0);
    chk("done_one_cycle", done_a, 0);
    chk("done_count", done_cnt, 1);

    chk("wr_count", wr_addr_q.size(), 12);
    for (int i = 0; i < wr_addr_q.size() && i < 12; i++) begin
      chk($sformatf("wr_addr_%0d", i), wr_addr_q[i], i);
      chk($sformatf("wr_data_%0d", i), wr_data_q[i], exp_res(i));
    end

    chk("fill_latency_lat3", b_vcyc - b_first, 12);
    for (int k = 0; k < 9; k++)
      chk($sformatf("lat3_slot_%0d", k), win_data_b[k*PW +: PW], 10 + k);

    // Abandon the second image part-way through fetching pixel 5.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int p = 0; p < 5; p++) do_pixel(p, 0);
    for (int i = 0; i < 40 && rdq.size() < 3; i++) @(negedge clk);
    chk("p5_fetch_started", rdq.size() >= 3, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_rd_en", rd_en_a, 0);
    chk("midrst_rd_addr", rd_addr_a, 0);
    chk("midrst_win_valid", win_valid_a, 0);
    chk("midrst_win_data_zero", win_data_a == '0, 1);
    chk("midrst_wr_en", wr_en_a, 0);
    chk("midrst_done", done_a, 0);
    rst = 1'b1;
    done_before = done_cnt;
    rdq.delete();
    repeat (20) @(negedge clk);
    chk("no_done_after_abort", done_cnt, done_before);
    chk("idle_after_abort", busy_a, 0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && rdq.size() < 3; i++) @(negedge clk);
    chk("restart_reads", rdq.size() >= 3, 1);
    if (rdq.size() >= 3) begin
      chk("restart_addr0", rdq[0], 0);
      chk("restart_addr1", rdq[1], 0);
      chk("restart_addr2", rdq[2], 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
